// File: rtl/sram_read_arbiter.sv
// Three-way read arbiter for a single-ported SRAM read channel.
// Requester 0 (VGA fetch) has priority. If the VGA stream has held the port
// for MAX_BURST consecutive beats, it is held off for one beat so that
// requesters 1 and 2 make progress. Requesters 1 and 2 share round-robin
// bursts of up to MAX_BURST beats. Grants are combinational, so a request
// that arrives while the port is idle is granted in the same cycle.
module sram_read_arbiter #(
  parameter int AW        = 18,
  parameter int DW        = 16,
  parameter int MAX_BURST = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [2:0]      req,
  input  logic [3*AW-1:0] addr,
  output logic [2:0]      gnt,
  output logic [2:0]      rvalid,
  output logic [DW-1:0]   rdata,
  output logic [AW-1:0]   sram_raddr,
  input  logic [DW-1:0]   sram_rdata,
  output logic            busy
);

  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] BURST_MAX = CW'(MAX_BURST);
  localparam logic [CW-1:0] ONE       = CW'(1);

  typedef enum logic [1:0] {
    OWN_VGA  = 2'd0,
    OWN_UPS  = 2'd1,
    OWN_CNV  = 2'd2,
    OWN_NONE = 2'd3
  } owner_t;

  owner_t          owner_reg, owner_next;
  logic [CW-1:0]   beat_cnt_reg, beat_cnt_next;
  logic [CW-1:0]   vga_streak_reg, vga_streak_next;
  // 0 = requester 1 is preferred next, 1 = requester 2 is preferred next
  logic            rr_next_reg, rr_next_next;
  logic [2:0]      rvalid_reg;
  logic [AW-1:0]   raddr_reg;

  logic [AW-1:0]   addr_arr [3];
  logic [2:0]      gnt_comb;
  logic            owner_is_low, owner_req, owner_cont, owner_other;
  logic            rr_pref, low_valid, vga_block, vga_win;
  owner_t          low_pick;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_addr
      assign addr_arr[gi] = addr[gi*AW +: AW];
    end
  endgenerate

  function automatic logic [2:0] onehot(input owner_t o);
    case (o)
      OWN_VGA: return 3'b001;
      OWN_UPS: return 3'b010;
      OWN_CNV: return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  // Decode the current owner: is it still requesting, and may it keep the port?
  always_comb begin
    owner_is_low = (owner_reg == OWN_UPS) || (owner_reg == OWN_CNV);
    owner_req    = |(onehot(owner_reg) & req);
    owner_cont   = owner_req && (beat_cnt_reg < BURST_MAX);
    owner_other  = (owner_reg == OWN_UPS);
    // A low owner that is being re-arbitrated hands preference to its peer.
    rr_pref      = owner_is_low ? owner_other : rr_next_reg;
    low_valid    = req[1] | req[2];
    low_pick     = OWN_NONE;
    if (!rr_pref) begin
      if (req[1])      low_pick = OWN_UPS;
      else if (req[2]) low_pick = OWN_CNV;
    end else begin
      if (req[2])      low_pick = OWN_CNV;
      else if (req[1]) low_pick = OWN_UPS;
    end
    vga_block = (vga_streak_reg == BURST_MAX) && low_valid;
    vga_win   = req[0] && !vga_block;
  end

  // Next-state and grant selection for the owner FSM.
  always_comb begin
    owner_next      = owner_reg;
    beat_cnt_next   = beat_cnt_reg;
    rr_next_next    = rr_next_reg;
    vga_streak_next = '0;
    gnt_comb        = 3'b000;
    if (vga_win) begin
      gnt_comb        = 3'b001;
      vga_streak_next = (vga_streak_reg == BURST_MAX) ? BURST_MAX : vga_streak_reg + ONE;
      if (owner_reg == OWN_VGA && owner_cont) begin
        beat_cnt_next = beat_cnt_reg + ONE;
      end else begin
        owner_next    = OWN_VGA;
        beat_cnt_next = ONE;
      end
      // A preempted low-priority burst still counts as ended.
      if (owner_is_low) rr_next_next = owner_other;
    end else if (owner_is_low && owner_cont) begin
      gnt_comb      = onehot(owner_reg);
      beat_cnt_next = beat_cnt_reg + ONE;
    end else begin
      if (owner_is_low) rr_next_next = owner_other;
      if (low_valid) begin
        owner_next    = low_pick;
        beat_cnt_next = ONE;
        gnt_comb      = onehot(low_pick);
      end else begin
        owner_next    = OWN_NONE;
        beat_cnt_next = '0;
      end
    end
  end

  // Grants are suppressed while reset is held; the address follows the grant.
  always_comb begin
    gnt        = reset ? gnt_comb : 3'b000;
    sram_raddr = raddr_reg;
    for (int i = 0; i < 3; i++) begin
      if (gnt[i]) sram_raddr = addr_arr[i];
    end
  end

  // Arbitration state, read-valid pipeline and held address register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner_reg      <= OWN_NONE;
      beat_cnt_reg   <= '0;
      vga_streak_reg <= '0;
      rr_next_reg    <= 1'b0;
      rvalid_reg     <= 3'b000;
      raddr_reg      <= '0;
    end else begin
      owner_reg      <= owner_next;
      beat_cnt_reg   <= beat_cnt_next;
      vga_streak_reg <= vga_streak_next;
      rr_next_reg    <= rr_next_next;
      rvalid_reg     <= gnt;
      raddr_reg      <= sram_raddr;
    end
  end

  assign rvalid = rvalid_reg;
  assign rdata  = sram_rdata;
  assign busy   = (owner_reg != OWN_NONE);

endmodule

// File: tb/tb_sram_read_arbiter.sv
// Directed bench for sram_read_arbiter: a vector table for single-cycle
// behaviour, then hand-written sequences for bursts, VGA fairness,
// preemption, reset mid-burst and idle hold.
module tb_sram_read_arbiter;

  localparam int AW = 18;
  localparam int DW = 16;

  localparam logic [AW-1:0] A0 = 18'h00A00;
  localparam logic [AW-1:0] A1 = 18'h00100;
  localparam logic [AW-1:0] A2 = 18'h00200;

  logic            clk = 1'b0;
  logic            reset;
  logic [2:0]      req;
  logic [AW-1:0]   a0, a1, a2;
  logic [3*AW-1:0] addr;
  logic [2:0]      gnt, rvalid;
  logic [DW-1:0]   rdata, sram_rdata;
  logic [AW-1:0]   sram_raddr;
  logic            busy;

  int checks = 0;
  int errors = 0;

  assign addr = {a2, a1, a0};

  sram_read_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(8)) dut (
    .clk(clk), .reset(reset), .req(req), .addr(addr), .gnt(gnt),
    .rvalid(rvalid), .rdata(rdata), .sram_raddr(sram_raddr),
    .sram_rdata(sram_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return a[DW-1:0] ^ 16'h5A5A;
  endfunction

  // SRAM model: data for the address presented one cycle earlier.
  always @(posedge clk) sram_rdata <= mem_word(sram_raddr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic apply(input logic [2:0] r);
    @(negedge clk);
    req = r;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    req   = 3'b000;
    a0 = A0; a1 = A1; a2 = A2;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  typedef struct {
    logic [2:0]    req;
    logic [AW-1:0] a1;
    logic [2:0]    gnt;
    logic [2:0]    rvalid;
    logic [AW-1:0] raddr;
    logic          busy;
  } vec_t;

  vec_t vecs [14];
  logic [AW-1:0] prev_raddr;
  logic [2:0]    exp_g, prev_g;
  logic [AW-1:0] exp_a, prev_a;

  initial begin
    vecs[0]  = '{3'b000, A1,       3'b000, 3'b000, 18'h00000, 1'b0};
    vecs[1]  = '{3'b010, A1,       3'b010, 3'b000, A1,        1'b0};
    vecs[2]  = '{3'b010, A1,       3'b010, 3'b010, A1,        1'b1};
    vecs[3]  = '{3'b000, A1,       3'b000, 3'b010, A1,        1'b1};
    vecs[4]  = '{3'b110, A1,       3'b100, 3'b000, A2,        1'b0};
    vecs[5]  = '{3'b111, A1,       3'b001, 3'b100, A0,        1'b1};
    vecs[6]  = '{3'b110, A1,       3'b010, 3'b001, A1,        1'b1};
    vecs[7]  = '{3'b100, A1,       3'b100, 3'b010, A2,        1'b1};
    vecs[8]  = '{3'b000, A1,       3'b000, 3'b100, A2,        1'b1};
    vecs[9]  = '{3'b001, A1,       3'b001, 3'b000, A0,        1'b0};
    vecs[10] = '{3'b000, A1,       3'b000, 3'b001, A0,        1'b1};
    vecs[11] = '{3'b000, A1,       3'b000, 3'b000, A0,        1'b0};
    vecs[12] = '{3'b010, 18'h3FFFF, 3'b010, 3'b000, 18'h3FFFF, 1'b0};
    vecs[13] = '{3'b000, 18'h3FFFF, 3'b000, 3'b010, 18'h3FFFF, 1'b1};

    // Reset state, with every requester asking: nothing may be granted.
    reset = 1'b0;
    req   = 3'b000;
    a0 = A0; a1 = A1; a2 = A2;
    repeat (3) @(negedge clk);
    req = 3'b111;
    #1;
    check("rst_gnt", 32'(gnt), 32'(3'b000));
    check("rst_raddr", 32'(sram_raddr), 32'h0);
    check("rst_rvalid", 32'(rvalid), 32'(3'b000));
    check("rst_busy", 32'(busy), 32'h0);
    @(negedge clk);
    req   = 3'b000;
    reset = 1'b1;

    // Table-driven single-cycle vectors.
    prev_raddr = '0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      req = vecs[i].req;
      a1  = vecs[i].a1;
      #1;
      $display("vec %0d: req=%b gnt=%b rvalid=%b raddr=%0h busy=%b", i, req, gnt, rvalid, sram_raddr, busy);
      check($sformatf("vec%0d_gnt", i), 32'(gnt), 32'(vecs[i].gnt));
      check($sformatf("vec%0d_rvalid", i), 32'(rvalid), 32'(vecs[i].rvalid));
      check($sformatf("vec%0d_raddr", i), 32'(sram_raddr), 32'(vecs[i].raddr));
      check($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].busy));
      if (vecs[i].rvalid != 3'b000)
        check($sformatf("vec%0d_rdata", i), 32'(rdata), 32'(mem_word(prev_raddr)));
      prev_raddr = vecs[i].raddr;
    end

    // Requesters 1 and 2 both held: 8-beat bursts alternating 1,2,1.
    do_reset();
    prev_g = 3'b000;
    prev_a = '0;
    for (int k = 0; k < 24; k++) begin
      apply(3'b110);
      exp_g = (((k / 8) % 2) == 0) ? 3'b010 : 3'b100;
      exp_a = (exp_g == 3'b010) ? A1 : A2;
      $display("rr k=%0d: gnt=%b raddr=%0h rvalid=%b", k, gnt, sram_raddr, rvalid);
      check($sformatf("rr%0d_gnt", k), 32'(gnt), 32'(exp_g));
      check($sformatf("rr%0d_raddr", k), 32'(sram_raddr), 32'(exp_a));
      if (k > 0) begin
        check($sformatf("rr%0d_rvalid", k), 32'(rvalid), 32'(prev_g));
        check($sformatf("rr%0d_rdata", k), 32'(rdata), 32'(mem_word(prev_a)));
      end
      prev_g = exp_g;
      prev_a = exp_a;
    end

    // Idle after the bursts: address held at the last grant (requester 1).
    for (int k = 0; k < 5; k++) begin
      apply(3'b000);
      $display("idle k=%0d: gnt=%b raddr=%0h busy=%b", k, gnt, sram_raddr, busy);
      check($sformatf("idle%0d_gnt", k), 32'(gnt), 32'(3'b000));
      check($sformatf("idle%0d_raddr", k), 32'(sram_raddr), 32'(A1));
      check($sformatf("idle%0d_busy", k), 32'(busy), (k == 0) ? 32'h1 : 32'h0);
    end

    // VGA plus requester 1 held: 8 VGA beats, then one beat for requester 1.
    do_reset();
    for (int k = 0; k < 36; k++) begin
      apply(3'b011);
      exp_g = ((k % 9) < 8) ? 3'b001 : 3'b010;
      $display("fair k=%0d: gnt=%b", k, gnt);
      check($sformatf("fair%0d_gnt", k), 32'(gnt), 32'(exp_g));
    end

    // Owner 2 at beat 3 is preempted by VGA; requester 1 is preferred afterwards.
    do_reset();
    apply(3'b010);
    check("pre_g1", 32'(gnt), 32'(3'b010));
    apply(3'b000);
    check("pre_idle", 32'(gnt), 32'(3'b000));
    for (int k = 0; k < 3; k++) begin
      apply(3'b100);
      $display("pre k=%0d: gnt=%b", k, gnt);
      check($sformatf("pre_own2_%0d", k), 32'(gnt), 32'(3'b100));
    end
    apply(3'b101);
    $display("pre vga: gnt=%b raddr=%0h", gnt, sram_raddr);
    check("pre_vga_gnt", 32'(gnt), 32'(3'b001));
    check("pre_vga_raddr", 32'(sram_raddr), 32'(A0));
    apply(3'b110);
    $display("pre after: gnt=%b", gnt);
    check("pre_rr1", 32'(gnt), 32'(3'b010));

    // Reset pulse mid-burst with VGA requesting after release.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      apply(3'b010);
      check($sformatf("mr_a_burst%0d", k), 32'(gnt), 32'(3'b010));
    end
    @(negedge clk);
    reset = 1'b0;
    req   = 3'b011;
    #1;
    $display("mr_a in reset: gnt=%b rvalid=%b", gnt, rvalid);
    check("mr_a_rst_gnt", 32'(gnt), 32'(3'b000));
    check("mr_a_rst_rvalid", 32'(rvalid), 32'(3'b000));
    @(negedge clk);
    reset = 1'b1;
    #1;
    $display("mr_a release: gnt=%b rvalid=%b", gnt, rvalid);
    check("mr_a_rel_gnt", 32'(gnt), 32'(3'b001));
    check("mr_a_rel_rvalid", 32'(rvalid), 32'(3'b000));
    apply(3'b011);
    check("mr_a_rvalid", 32'(rvalid), 32'(3'b001));

    // Reset pulse mid-burst of requester 2 (preference was on 2); release prefers 1.
    do_reset();
    apply(3'b010);
    check("mr_b_g1", 32'(gnt), 32'(3'b010));
    apply(3'b100);
    check("mr_b_g2a", 32'(gnt), 32'(3'b100));
    apply(3'b110);
    check("mr_b_g2b", 32'(gnt), 32'(3'b100));
    @(negedge clk);
    reset = 1'b0;
    req   = 3'b110;
    #1;
    check("mr_b_rst_gnt", 32'(gnt), 32'(3'b000));
    check("mr_b_rst_rvalid", 32'(rvalid), 32'(3'b000));
    check("mr_b_rst_busy", 32'(busy), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    $display("mr_b release: gnt=%b rvalid=%b", gnt, rvalid);
    check("mr_b_rel_gnt", 32'(gnt), 32'(3'b010));
    check("mr_b_rel_rvalid", 32'(rvalid), 32'(3'b000));
    apply(3'b000);
    check("mr_b_rvalid", 32'(rvalid), 32'(3'b010));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_read_arbiter.md
SRAM_READ_ARBITER -- requirements
Module: sram_read_arbiter

Interface
REQ-001 SHALL have parameter AW, default 18, meaning SRAM address width.
REQ-002 SHALL have parameter DW, default 16, meaning SRAM data width.
REQ-003 SHALL have parameter MAX_BURST, default 8, meaning the maximum number of consecutive beats granted to one requester before arbitration is forced (legal range 2..255).
REQ-004 SHALL have port clk, input, 1, meaning the single system clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1, meaning the asynchronous, active-low reset (low = in reset).
REQ-006 SHALL have port req, input, 3, meaning per-requester read request: bit0 = VGA fetch, bit1 = upsample, bit2 = conversion.
REQ-007 SHALL have port addr, input, 3*AW, meaning per-requester read address, with requester i at bits [i*AW +: AW].
REQ-008 SHALL have port gnt, output, 3, meaning a one-hot or zero read grant; gnt[i] = 1 means addr[i] is issued this cycle.
REQ-009 SHALL have port rvalid, output, 3, meaning a one-hot or zero read-data valid; rvalid[i] = 1 means rdata belongs to requester i.
REQ-010 SHALL have port rdata, output, DW, meaning read data, a combinational pass-through of sram_rdata.
REQ-011 SHALL have port sram_raddr, output, AW, meaning the address driven to the SRAM read-only port.
REQ-012 SHALL have port sram_rdata, input, DW, meaning SRAM read data, valid one cycle after sram_raddr is presented.
REQ-013 SHALL have port busy, output, 1, meaning some requester currently owns the port (owner != NONE).

Function
REQ-014 SHALL issue at most one SRAM read per cycle; gnt is combinational from the registered state and the current req; at most one gnt bit is high.
REQ-015 SHALL never assert gnt[i] while req[i] = 0.
REQ-016 SHALL drive sram_raddr = addr[i] combinationally in a cycle with gnt[i] = 1; in a cycle with no grant, sram_raddr SHALL hold the last granted address (held register, reset 0).
REQ-017 SHALL assert rvalid[i] exactly one cycle after gnt[i]: rvalid is a register loaded with gnt every cycle.
REQ-018 SHALL keep registered state: owner (NONE/0/1/2), beat_cnt (counts consecutive beats of owner, 0..MAX_BURST), rr_next (1 or 2, the next low-priority requester to be preferred), vga_streak (consecutive VGA beats, 0..MAX_BURST).
REQ-019 SHALL, while the owner keeps req high and beat_cnt < MAX_BURST, continue granting the owner and increment beat_cnt on each grant.
REQ-020 SHALL re-arbitrate in a cycle when owner = NONE, the owner's req = 0, or beat_cnt = MAX_BURST.
REQ-021 SHALL give requester 0 (VGA) priority: if req[0] = 1, VGA wins any arbitration and also preempts a lower owner immediately in that same cycle, unless REQ-022 applies.
REQ-022 SHALL, when vga_streak = MAX_BURST and req[1] or req[2] is high, deny VGA for exactly one cycle, grant that cycle to the low-priority winner, and clear vga_streak.
REQ-023 SHALL choose between requesters 1 and 2 round-robin: rr_next wins if requesting, else the other; when a burst of 1 or 2 ends (switch or limit), rr_next SHALL be set to the other requester.
REQ-024 SHALL, on a switch of owner, load owner with the winner and set beat_cnt = 1; with no requests, owner SHALL become NONE, beat_cnt 0, gnt = 0.
REQ-025 SHALL increment vga_streak on each VGA grant and clear it on any cycle without a VGA grant.
REQ-026 SHALL have zero added latency: a request from IDLE is granted in the same cycle as req rises.

Reset
REQ-027 SHALL, while reset = 0 (asynchronously), force owner = NONE, beat_cnt = 0, vga_streak = 0, rr_next = 1, rvalid = 0, held sram_raddr = 0, busy = 0; gnt SHALL be 0 during reset.
REQ-028 SHALL discard any in-flight read when reset is asserted mid-burst; no rvalid SHALL follow the deassertion of reset for that read.

Verification
REQ-029 SHALL be verified with: req=3'b010, addr1=0x100 held → gnt=3'b010 in the same cycle, sram_raddr=0x100, rvalid=3'b010 next cycle, rdata = SRAM word at 0x100.
REQ-030 SHALL be verified with: req=3'b110 held for 20 cycles, MAX_BURST=8 → bursts of 8 beats alternating owner 1, 2, 1 (starting with 1), with no idle cycle between bursts.
REQ-031 SHALL be verified with: owner 2 at beat 3 when req[0] rises → gnt=3'b001 in that cycle; rr_next=1 afterwards.
REQ-032 SHALL be verified with: req=3'b011 held → 8 VGA grants, 1 grant to requester 1, 8 VGA grants, repeating.
REQ-033 SHALL be verified with: reset pulled low for 1 cycle mid-burst → gnt and rvalid go 0 immediately; the first grant after release goes to VGA if it is requesting, else to requester 1.
REQ-034 SHALL be verified with: req=3'b000 for 5 cycles → gnt=0, busy=0, and sram_raddr held at the last granted address.
